// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed scan controller for a 4-digit
// common-anode 7-segment display. Scans the four nibbles of a
// double-buffered 16-bit value and drives the downstream hex decoder
// (hex = 4'hF blanks a digit) and the active-low anode enables.
//
// Optional feature: define LEAD_ZERO_BLANK_EN to blank leading zero
// digits (digit 0 is always shown). Without the macro every enabled
// digit shows its nibble, leading zeros included.
module display_scanner #(
  parameter int DIV   = 100000,  // clock cycles per digit slot, >= 4
  parameter int GUARD = 2        // dark cycles at the start of each slot, < DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  digit_mask,
  output logic [3:0]  hex,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD  = CW'(GUARD);
  localparam logic [1:0]    DIGIT_LAST = 2'd3;

  // State registers and their next-state values
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [1:0]    digit_q,   digit_d;
  logic [15:0]   shadow_q,  shadow_d;
  logic [15:0]   shown_q,   shown_d;
  logic          pending_q, pending_d;
  logic [3:0]    mask_q,    mask_d;
  logic          frame_q,   frame_d;

  // Decode helpers
  logic          slot_end_s;
  logic          boundary_s;
  logic          guard_s;
  logic          blank_lz_s;
  logic [3:0]    nibble_s;
  logic [3:0]    an_lit_s;

`ifdef LEAD_ZERO_BLANK_EN
  // True when digit d (d >= 1) and every higher nibble of v are zero
  function automatic logic lead_zero(input logic [15:0] v, input logic [1:0] d);
    logic z;
    case (d)
      2'd0:    z = 1'b0;
      2'd1:    z = (v[15:4]  == 12'h000);
      2'd2:    z = (v[15:8]  == 8'h00);
      2'd3:    z = (v[15:12] == 4'h0);
      default: z = 1'b0;
    endcase
    return z;
  endfunction
`endif

  // Slot timing: wrap detection and the frame boundary (last cycle of digit 3)
  always_comb begin
    slot_end_s = (cnt_q == CNT_LAST);
    boundary_s = slot_end_s && (digit_q == DIGIT_LAST);
  end

  // Next state for slot counter, digit index and sampled mask
  always_comb begin
    cnt_d   = cnt_q;
    digit_d = digit_q;
    mask_d  = mask_q;
    if (slot_end_s) begin
      cnt_d   = {CW{1'b0}};
      digit_d = digit_q + 2'd1;
      mask_d  = digit_mask;
    end else begin
      cnt_d   = cnt_q + CW'(1);
    end
  end

  // Double buffer: loads land in shadow; shown only changes at a frame boundary
  always_comb begin
    shadow_d  = shadow_q;
    shown_d   = shown_q;
    pending_d = pending_q;
    frame_d   = 1'b0;
    if (load) begin
      shadow_d = value;
    end else begin
      shadow_d = shadow_q;
    end
    if (boundary_s) begin
      frame_d   = 1'b1;
      pending_d = 1'b0;
      if (load) begin
        // A load on the boundary edge bypasses the shadow wait
        shown_d = value;
      end else if (pending_q) begin
        shown_d = shadow_q;
      end else begin
        shown_d = shown_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  // Register update with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= {CW{1'b0}};
      digit_q   <= 2'd0;
      shadow_q  <= 16'h0000;
      shown_q   <= 16'h0000;
      pending_q <= 1'b0;
      mask_q    <= 4'b0000;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      shadow_q  <= shadow_d;
      shown_q   <= shown_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      frame_q   <= frame_d;
    end
  end

  // Select the current digit's nibble and its anode pattern
  always_comb begin
    nibble_s = 4'hF;
    an_lit_s = 4'b1111;
    case (digit_q)
      2'd0: begin nibble_s = shown_q[3:0];   an_lit_s = 4'b1110; end
      2'd1: begin nibble_s = shown_q[7:4];   an_lit_s = 4'b1101; end
      2'd2: begin nibble_s = shown_q[11:8];  an_lit_s = 4'b1011; end
      2'd3: begin nibble_s = shown_q[15:12]; an_lit_s = 4'b0111; end
      default: begin nibble_s = 4'hF; an_lit_s = 4'b1111; end
    endcase
  end

  // Dark conditions: guard interval at slot start, and optional leading-zero blanking
  always_comb begin
    guard_s = (cnt_q < CNT_GUARD);
`ifdef LEAD_ZERO_BLANK_EN
    blank_lz_s = lead_zero(shown_q, digit_q);
`else
    blank_lz_s = 1'b0;
`endif
  end

  // Output decode from registers only, so anodes never glitch on input changes
  always_comb begin
    an  = 4'b1111;
    hex = 4'hF;
    if (guard_s || !mask_q[digit_q] || blank_lz_s) begin
      an  = 4'b1111;
      hex = 4'hF;
    end else begin
      an  = an_lit_s;
      hex = nibble_s;
    end
  end

  assign pending = pending_q;
  assign frame   = frame_q;

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner (DIV=8, GUARD=2).
// A time-based model (cycle count since reset -> slot, digit, position)
// is compared against the DUT on every falling edge; directed steps add
// hand-computed literal expectations.
module tb_display_scanner;

  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  digit_mask = 4'hF;
  logic [3:0]  hex;
  logic [3:0]  an;
  logic        pending;
  logic        frame;

  int checks = 0;
  int errors = 0;

  // Model state
  int          m_t = 0;
  logic [15:0] m_shown = 16'h0000;
  logic [15:0] m_latest = 16'h0000;
  logic        m_pend = 1'b0;
  logic [3:0]  m_mask = 4'h0;
  logic        m_frame = 1'b0;

  logic [3:0] an_exp [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  always #5 clk = ~clk;

  display_scanner #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .digit_mask (digit_mask),
    .hex        (hex),
    .an         (an),
    .pending    (pending),
    .frame      (frame)
  );

  // Model: m_t counts cycles since reset; slot/digit follow from it arithmetically
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t      <= 0;
      m_shown  <= 16'h0000;
      m_latest <= 16'h0000;
      m_pend   <= 1'b0;
      m_mask   <= 4'h0;
      m_frame  <= 1'b0;
    end else begin
      m_t     <= m_t + 1;
      m_frame <= ((m_t % FRAME) == FRAME - 1);
      if ((m_t % DIV) == DIV - 1) m_mask <= digit_mask;
      if (load) m_latest <= value;
      if ((m_t % FRAME) == FRAME - 1) begin
        if (load) m_shown <= value;
        else if (m_pend) m_shown <= m_latest;
        m_pend <= 1'b0;
      end else if (load) begin
        m_pend <= 1'b1;
      end
    end
  end

  function automatic bit model_lit();
    int pos = m_t % DIV;
    int dig = (m_t / DIV) % 4;
    bit on;
    on = (pos >= GUARD) && m_mask[dig];
`ifdef LEAD_ZERO_BLANK_EN
    if (dig >= 1 && (m_shown >> (4 * dig)) == 16'h0000) on = 1'b0;
`endif
    return on;
  endfunction

  function automatic logic [3:0] model_an();
    int dig = (m_t / DIV) % 4;
    logic [3:0] one_hot;
    one_hot = 4'b0001 << dig;
    return model_lit() ? ~one_hot : 4'hF;
  endfunction

  function automatic logic [3:0] model_hex();
    int dig = (m_t / DIV) % 4;
    logic [3:0] nib;
    nib = m_shown[4 * dig +: 4];
    return model_lit() ? nib : 4'hF;
  endfunction

  task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %h expected %h", name, m_t, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %b expected %b", name, m_t, got, exp);
    end
  endtask

  // Continuous compare against the model, away from the active edge
  always @(negedge clk) begin
    chk4("model_an", an, model_an());
    chk4("model_hex", hex, model_hex());
    chk1("model_pending", pending, m_pend);
    chk1("model_frame", frame, m_frame);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int target);
    int n = 0;
    while ((m_t % FRAME) != target && n < 2 * FRAME) begin
      step();
      n++;
    end
    if ((m_t % FRAME) != target) begin
      checks++;
      errors++;
      $display("FAIL goto_timeout target=%0d got %0d", target, m_t % FRAME);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  // Visit each digit just after its guard interval and check literal outputs
  task automatic chk_frame(input string name, input logic [15:0] word, input logic [3:0] lit);
    logic [3:0] ea;
    logic [3:0] eh;
    for (int d = 0; d < 4; d++) begin
      goto(d * DIV + GUARD);
      ea = lit[d] ? an_exp[d] : 4'hF;
      eh = lit[d] ? word[4 * d +: 4] : 4'hF;
      chk4({name, "_an"}, an, ea);
      chk4({name, "_hex"}, hex, eh);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen1;
    bit seen2;

    // Reset state
    step(); step(); step();
    chk4("rst_an", an, 4'hF);
    chk4("rst_hex", hex, 4'hF);
    chk1("rst_pending", pending, 1'b0);
    chk1("rst_frame", frame, 1'b0);
    rst_n = 1'b1;

    // Slot 0 is dark (mask_q still 0), slot 1 lights digit 1 after the guard
    for (int i = 0; i < DIV; i++) begin
      chk4("slot0_dark", an, 4'hF);
      step();
    end
    for (int i = 0; i < DIV; i++) begin
      chk4("slot1_an", an, (i < GUARD) ? 4'hF : 4'hD);
      chk4("slot1_hex", hex, (i < GUARD) ? 4'hF : 4'h0);
      step();
    end

    // Mid-frame load waits for the boundary
    goto(4);
    pulse_load(16'h1234);
    chk1("load_pending", pending, 1'b1);
    chk4("load_no_early", hex, 4'h0);
    goto(0);
    chk1("boundary_frame", frame, 1'b1);
    chk1("boundary_pending", pending, 1'b0);
    step();
    chk1("frame_one_cycle", frame, 1'b0);
    chk_frame("f1234", 16'h1234, 4'hF);

    // Two loads in one frame: the last one wins
    goto(5);
    pulse_load(16'h1111);
    goto(20);
    pulse_load(16'h2222);
    goto(0);
    seen1 = 1'b0;
    seen2 = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if (an != 4'hF && hex == 4'h1) seen1 = 1'b1;
      if (an != 4'hF && hex == 4'h2) seen2 = 1'b1;
      step();
    end
    chk1("overwrite_no_1111", seen1, 1'b0);
    chk1("overwrite_shows_2222", seen2, 1'b1);

    // Load exactly on the boundary edge
    goto(FRAME - 1);
    pulse_load(16'hABCD);
    chk1("edge_load_pending", pending, 1'b0);
    chk1("edge_load_frame", frame, 1'b1);
    chk_frame("fabcd", 16'hABCD, 4'hF);

    // Digit mask 0101
    digit_mask = 4'b0101;
    goto(4);
    pulse_load(16'h9876);
    goto(0);
    chk_frame("mask0101", 16'h9876, 4'b0101);

    // Leading zeros
    digit_mask = 4'hF;
    goto(0);
    goto(4);
    pulse_load(16'h0050);
    goto(0);
`ifdef LEAD_ZERO_BLANK_EN
    chk_frame("f0050", 16'h0050, 4'b0011);
`else
    chk_frame("f0050", 16'h0050, 4'hF);
`endif

    // Reset mid-slot with a pending value
    goto(DIV + 4);
    pulse_load(16'h7777);
    chk1("pre_reset_pending", pending, 1'b1);
    rst_n = 1'b0;
    #1;
    chk4("async_rst_an", an, 4'hF);
    chk4("async_rst_hex", hex, 4'hF);
    chk1("async_rst_pending", pending, 1'b0);
    chk1("async_rst_frame", frame, 1'b0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) step();
    chk4("post_reset_digit0_hex", hex, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
